pass_checker: RTL and testbench
===============================

Name: pass_checker

Overview:
- Downstream consumer of the 8-bit registered pass-through DUT; sits on its data_out.
- Delays each stimulus byte applied to DUT data_in by the DUT latency, then compares it against the observed data_out.
- Counts checks and mismatches, and reports pass/fail/done to the bench or a top-level status register.
- Synthesizable, so it can run in a hardware self-check wrapper as well as in simulation.

Parameters:
- DATA_W, 8, width of compared data.
- LATENCY, 1, DUT input-to-output delay in clk cycles; legal range 1..8.
- CNT_W, 16, width of check and error counters.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms a run; ignored unless in IDLE.
- num_checks  input  CNT_W  number of comparisons per run; sampled on an accepted start.
- halt_on_err  input  1  sampled on start; 1 = stop at first mismatch.
- clear  input  1  returns DONE/FAIL to IDLE; ignored in other states.
- exp_valid  input  1  exp_data is being driven to DUT data_in this cycle.
- exp_data  input  DATA_W  stimulus value presented to the DUT.
- obs_data  input  DATA_W  DUT data_out.
- busy  output  1  high in RUN.
- done  output  1  high in DONE or FAIL.
- pass  output  1  high in DONE with err_cnt==0.
- fail  output  1  high in FAIL, or in DONE with err_cnt!=0.
- chk_cnt  output  CNT_W  comparisons performed this run.
- err_cnt  output  CNT_W  mismatches this run.
- first_err_exp  output  DATA_W  expected value at the first mismatch (optional feature).
- first_err_obs  output  DATA_W  observed value at the first mismatch (optional feature).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, delay line valid bits cleared, all outputs 0. Applies in any state, including mid-run; in-flight entries are lost.
- FSM states: IDLE, RUN, DONE, FAIL.
- IDLE -> RUN on start. At that edge: latch num_checks and halt_on_err, zero chk_cnt/err_cnt, flush the delay line.
- RUN:
  - A cycle with exp_valid=1 pushes {1, exp_data} into the delay line; exp_valid=0 pushes a bubble.
  - A valid entry exits exactly LATENCY cycles after its push. The exit cycle is a check cycle: compare against obs_data sampled on the same edge, chk_cnt+1, and err_cnt+1 on mismatch.
- RUN -> FAIL when a check mismatches and halt_on_err=1. FAIL has priority over DONE when this is also the final check.
- RUN -> DONE when chk_cnt reaches the latched num_checks, including the increment made that cycle.
- num_checks=0: RUN -> DONE on the first cycle after start; chk_cnt stays 0.
- Entries still in the delay line when leaving RUN are discarded. exp_valid outside RUN is ignored.
- DONE/FAIL hold all counters until clear, then -> IDLE. Counters are zeroed only by the next accepted start.
- start outside IDLE, or clear outside DONE/FAIL: no effect.
- Counters saturate at all-ones; no wrap.
- Compare is a full DATA_W bitwise equality; X/Z on obs_data counts as a mismatch in simulation.
- Status outputs are registered and decode from state one cycle after the transition edge.

Optional Feature:
- Macro: PASS_CHECKER_ERR_LOG_EN.
- Defined: on the first mismatch of a run, capture exp and obs into first_err_exp/first_err_obs. Captured values hold until the next accepted start, which clears them to 0.
- Undefined: no capture registers; first_err_exp and first_err_obs are tied to 0.

Decomposition:
- Package pass_checker_pkg holds:
  - typedef enum logic [1:0] chk_state_e {CHK_IDLE, CHK_RUN, CHK_DONE, CHK_FAIL};
  - localparam MAX_LATENCY = 8.
- Sub-module chk_delay_line:
  - parameters DATA_W, LATENCY; shift register of {valid, data}.
  - ports clk, rst, flush, in_valid, in_data, out_valid, out_data.
  - Instantiated once.

Test Plan:
- Pass run: start with num_checks=3, halt_on_err=0; drive 8'hFF, 8'hAA, 8'h55 with obs equal after 1 cycle -> done=1, pass=1, chk_cnt=3, err_cnt=0.
- Continue on error: start with num_checks=2, halt_on_err=0; exp 8'hAA then 8'h11, obs 8'hAA then 8'h10 -> DONE, fail=1, err_cnt=1, chk_cnt=2; first_err_exp=8'h11, first_err_obs=8'h10 when PASS_CHECKER_ERR_LOG_EN is defined.
- Halt on error: start with num_checks=5, halt_on_err=1; mismatch on the 2nd check -> FAIL the following edge, chk_cnt=2, err_cnt=1, busy=0.
- Bubbles and latency: LATENCY=3; exp_valid pattern 1,0,1 -> checks occur exactly 3 cycles after each valid push, chk_cnt=2, no check on the bubble cycle.
- Boundaries: num_checks=0 -> done=1, pass=1 one cycle after busy rises; start pulsed while busy -> chk_cnt unaffected; clear in DONE -> IDLE, counters retained.
- Reset mid-run: assert rst after 2 of 4 checks -> next cycle state=IDLE, all outputs 0; a new start runs cleanly with no stale delay-line entries checked.

Source files
------------

// File: rtl/pass_checker_pkg.sv
// pass_checker_pkg: state encoding and limits shared by pass_checker and its delay line.
package pass_checker_pkg;

    typedef enum logic [1:0] {CHK_IDLE, CHK_RUN, CHK_DONE, CHK_FAIL} chk_state_e;

    localparam int MAX_LATENCY = 8;

endpackage

// File: rtl/chk_delay_line.sv
// chk_delay_line: LATENCY-deep shift register of {valid, data} that mirrors the DUT pipeline.
module chk_delay_line
    import pass_checker_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("chk_delay_line: LATENCY must be within 1..MAX_LATENCY");
    end

    logic [LATENCY-1:0]        v;
    logic [LATENCY*DATA_W-1:0] d;

    // Only the valid bits need clearing; stale data behind a cleared valid is never compared.
    always_ff @(posedge clk) begin
        v <= (rst || flush) ? '0 : (v << 1) | LATENCY'(in_valid);
        d <= (d << DATA_W) | (LATENCY*DATA_W)'(in_data);
    end

    assign out_valid = v[LATENCY-1];
    assign out_data  = d[LATENCY*DATA_W-1 -: DATA_W];

endmodule

// File: rtl/pass_checker.sv
// pass_checker: compares DUT output against stimulus delayed by the DUT latency, counts checks/errors.
// Optional first-mismatch capture is enabled by defining PASS_CHECKER_ERR_LOG_EN.
module pass_checker
    import pass_checker_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_checks,
    input  logic              halt_on_err,
    input  logic              clear,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] obs_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  chk_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_obs
);

    chk_state_e        state;
    logic [CNT_W-1:0]  n_lat;
    logic              halt_lat;
    logic              run;
    logic              hit;
    logic              miss;
    logic              dl_valid;
    logic [DATA_W-1:0] dl_data;
    logic [CNT_W-1:0]  chk_nxt;
    logic [CNT_W-1:0]  err_nxt;

    assign run = state == CHK_RUN;

    // Holding flush outside RUN discards leftovers on exit and empties the line at the start edge.
    chk_delay_line #(.DATA_W(DATA_W), .LATENCY(LATENCY)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .flush    (!run),
        .in_valid (run && exp_valid),
        .in_data  (exp_data),
        .out_valid(dl_valid),
        .out_data (dl_data)
    );

    assign hit     = run && dl_valid;
    assign miss    = hit && (dl_data !== obs_data);
    assign chk_nxt = hit && ~&chk_cnt ? chk_cnt + 1'b1 : chk_cnt;
    assign err_nxt = miss && ~&err_cnt ? err_cnt + 1'b1 : err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CHK_IDLE;
            n_lat    <= '0;
            halt_lat <= 1'b0;
            chk_cnt  <= '0;
            err_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            busy <= state == CHK_RUN;
            done <= state == CHK_DONE || state == CHK_FAIL;
            pass <= state == CHK_DONE && err_cnt == '0;
            fail <= state == CHK_FAIL || (state == CHK_DONE && err_cnt != '0);
            case (state)
                CHK_IDLE: if (start) begin
                    state    <= CHK_RUN;
                    n_lat    <= num_checks;
                    halt_lat <= halt_on_err;
                    chk_cnt  <= '0;
                    err_cnt  <= '0;
                end
                CHK_RUN: begin
                    chk_cnt <= chk_nxt;
                    err_cnt <= err_nxt;
                    state   <= miss && halt_lat ? CHK_FAIL : chk_nxt == n_lat ? CHK_DONE : CHK_RUN;
                end
                default: if (clear) state <= CHK_IDLE;
            endcase
        end
    end

`ifdef PASS_CHECKER_ERR_LOG_EN
    always_ff @(posedge clk) begin
        if (rst || (state == CHK_IDLE && start)) begin
            first_err_exp <= '0;
            first_err_obs <= '0;
        end else if (miss && err_cnt == '0) begin
            first_err_exp <= dl_data;
            first_err_obs <= obs_data;
        end
    end
`else
    assign first_err_exp = '0;
    assign first_err_obs = '0;
`endif

endmodule

// File: tb/tb_pass_checker.sv
// tb_pass_checker: directed and randomized runs of pass_checker at LATENCY 1 and 3 against a list-based model.
module tb_pass_checker;

    localparam int DW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic halt_on_err = 1'b0;
    logic clear = 1'b0;
    logic exp_valid = 1'b0;
    logic [CW-1:0] num_checks = '0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] obs1 = '0;
    logic [DW-1:0] obs3 = '0;

    logic busy1, done1, pass1, fail1, busy3, done3, pass3, fail3;
    logic [CW-1:0] chk1, err1, chk3, err3;
    logic [DW-1:0] fe1, fo1, fe3, fo3;

    bit sel3 = 1'b0;
    logic o_busy, o_done, o_pass, o_fail;
    logic [CW-1:0] o_chk, o_err;
    logic [DW-1:0] o_fe, o_fo;
    assign o_busy = sel3 ? busy3 : busy1;
    assign o_done = sel3 ? done3 : done1;
    assign o_pass = sel3 ? pass3 : pass1;
    assign o_fail = sel3 ? fail3 : fail1;
    assign o_chk  = sel3 ? chk3  : chk1;
    assign o_err  = sel3 ? err3  : err1;
    assign o_fe   = sel3 ? fe3   : fe1;
    assign o_fo   = sel3 ? fo3   : fo1;

    int total = 0;
    int bad = 0;

    logic          vld_a [64];
    logic [DW-1:0] dat_a [64];
    logic [DW-1:0] flp_a [64];
    int            n_items;

    always #5 clk = ~clk;

    pass_checker #(.DATA_W(DW), .LATENCY(1), .CNT_W(CW)) u1 (
        .clk(clk), .rst(rst), .start(start1), .num_checks(num_checks), .halt_on_err(halt_on_err),
        .clear(clear), .exp_valid(exp_valid), .exp_data(exp_data), .obs_data(obs1),
        .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .chk_cnt(chk1), .err_cnt(err1),
        .first_err_exp(fe1), .first_err_obs(fo1)
    );

    pass_checker #(.DATA_W(DW), .LATENCY(3), .CNT_W(CW)) u3 (
        .clk(clk), .rst(rst), .start(start3), .num_checks(num_checks), .halt_on_err(halt_on_err),
        .clear(clear), .exp_valid(exp_valid), .exp_data(exp_data), .obs_data(obs3),
        .busy(busy3), .done(done3), .pass(pass3), .fail(fail3), .chk_cnt(chk3), .err_cnt(err3),
        .first_err_exp(fe3), .first_err_obs(fo3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic v, input logic [DW-1:0] d, input logic [DW-1:0] f);
        vld_a[i] = v;
        dat_a[i] = d;
        flp_a[i] = f;
    endtask

    task automatic check_idle_zero(input string tag);
        total++;
        if ({o_busy, o_done, o_pass, o_fail} !== 4'b0 || o_chk !== '0 || o_err !== '0 ||
            o_fe !== '0 || o_fo !== '0) begin
            bad++;
            $display("FAIL %s: busy/done/pass/fail=%b%b%b%b chk=%0d err=%0d fe=%h fo=%h, all required 0",
                     tag, o_busy, o_done, o_pass, o_fail, o_chk, o_err, o_fe, o_fo);
        end
    endtask

    // Plays the DUT (obs = exp delayed by L, xor injected flips) and checks per-cycle and final results.
    task automatic drive_run(input bit s3, input logic [CW-1:0] n, input logic h, input bit restart);
        int L = s3 ? 3 : 1;
        int k = 0;
        int e = 0;
        int seen = 0;
        bit fl = 1'b0;
        bit stop = (n == 0);
        logic [DW-1:0] fx = '0;
        logic [DW-1:0] fo = '0;
        logic [DW-1:0] ob;
        logic [CW-1:0] want;
        for (int j = 0; j < n_items && !stop; j++) begin
            if (vld_a[j]) begin
                k++;
                if (flp_a[j] != 0) begin
                    if (e == 0) begin
                        fx = dat_a[j];
                        fo = dat_a[j] ^ flp_a[j];
                    end
                    e++;
                end
                if (h && flp_a[j] != 0) begin
                    fl = 1'b1;
                    stop = 1'b1;
                end else if (k == int'(n)) stop = 1'b1;
            end
        end
`ifndef PASS_CHECKER_ERR_LOG_EN
        fx = '0;
        fo = '0;
`endif
        sel3 = s3;
        num_checks = n;
        halt_on_err = h;
        start1 = !s3;
        start3 = s3;
        cyc();
        start1 = 1'b0;
        start3 = 1'b0;
        num_checks = CW'($urandom);
        halt_on_err = 1'($urandom);
        for (int t = 0; t < n_items + L + 1; t++) begin
            exp_valid = t < n_items ? vld_a[t] : 1'($urandom);
            exp_data = t < n_items ? dat_a[t] : DW'($urandom);
            ob = (t >= L && t - L < n_items) ? dat_a[t-L] ^ flp_a[t-L] : DW'($urandom);
            obs1 = s3 ? DW'($urandom) : ob;
            obs3 = s3 ? ob : DW'($urandom);
            start1 = restart && !s3 && t == 1;
            start3 = restart && s3 && t == 1;
            cyc();
            if (t >= L && t - L < n_items && vld_a[t-L]) seen++;
            want = CW'(seen < k ? seen : k);
            total++;
            if (o_chk !== want) begin
                bad++;
                $display("FAIL chk_timing lat=%0d t=%0d: chk_cnt=%0d required=%0d", L, t, o_chk, want);
            end
        end
        exp_valid = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        for (int w = 0; w < 10 && o_done !== 1'b1; w++) cyc();
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_pass !== (!fl && e == 0) || o_fail !== (fl || e != 0)) begin
            bad++;
            $display("FAIL end_status lat=%0d n=%0d: done/busy/pass/fail=%b%b%b%b required %b%b%b%b",
                     L, n, o_done, o_busy, o_pass, o_fail, 1'b1, 1'b0, !fl && e == 0, fl || e != 0);
        end
        total++;
        if (o_chk !== CW'(k) || o_err !== CW'(e)) begin
            bad++;
            $display("FAIL end_counts lat=%0d n=%0d: chk=%0d err=%0d required chk=%0d err=%0d",
                     L, n, o_chk, o_err, k, e);
        end
        total++;
        if (o_fe !== fx || o_fo !== fo) begin
            bad++;
            $display("FAIL first_err lat=%0d: exp=%h obs=%h required exp=%h obs=%h", L, o_fe, o_fo, fx, fo);
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_chk !== CW'(k) || o_err !== CW'(e)) begin
            bad++;
            $display("FAIL after_clear: done=%b busy=%b chk=%0d err=%0d required done=0 busy=0 chk=%0d err=%0d",
                     o_done, o_busy, o_chk, o_err, k, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        sel3 = 1'b0;
        check_idle_zero("reset_l1");
        sel3 = 1'b1;
        check_idle_zero("reset_l3");
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_pass_run();
        n_items = 3;
        load(0, 1'b1, 8'hFF, 8'h00);
        load(1, 1'b1, 8'hAA, 8'h00);
        load(2, 1'b1, 8'h55, 8'h00);
        drive_run(1'b0, 16'd3, 1'b0, 1'b0);
    endtask

    task automatic test_continue_on_err();
        n_items = 2;
        load(0, 1'b1, 8'hAA, 8'h00);
        load(1, 1'b1, 8'h11, 8'h01);
        drive_run(1'b0, 16'd2, 1'b0, 1'b0);
    endtask

    task automatic test_halt_on_err();
        n_items = 5;
        for (int i = 0; i < 5; i++) load(i, 1'b1, DW'(8'h30 + i), i == 1 ? 8'h80 : 8'h00);
        drive_run(1'b0, 16'd5, 1'b1, 1'b0);
        n_items = 2;
        load(0, 1'b1, 8'h12, 8'h00);
        load(1, 1'b1, 8'h34, 8'h04);
        drive_run(1'b1, 16'd2, 1'b1, 1'b0);
    endtask

    task automatic test_bubbles();
        n_items = 3;
        load(0, 1'b1, 8'hC3, 8'h00);
        load(1, 1'b0, 8'h5A, 8'h00);
        load(2, 1'b1, 8'h3C, 8'h00);
        drive_run(1'b1, 16'd2, 1'b0, 1'b0);
    endtask

    task automatic test_zero_checks();
        sel3 = 1'b0;
        num_checks = '0;
        halt_on_err = 1'b0;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL zero_start_edge: busy=%b done=%b required 0 0", o_busy, o_done);
        end
        cyc();
        total++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL zero_busy: busy=%b done=%b required 1 0", o_busy, o_done);
        end
        cyc();
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b1 || o_pass !== 1'b1 || o_fail !== 1'b0 || o_chk !== '0) begin
            bad++;
            $display("FAIL zero_done: busy=%b done=%b pass=%b fail=%b chk=%0d required 0 1 1 0 0",
                     o_busy, o_done, o_pass, o_fail, o_chk);
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back_start();
        n_items = 4;
        for (int i = 0; i < 4; i++) load(i, 1'b1, DW'($urandom), 8'h00);
        drive_run(1'b0, 16'd3, 1'b0, 1'b1);
        n_items = 6;
        for (int i = 0; i < 6; i++) load(i, 1'b1, DW'($urandom), 8'h00);
        drive_run(1'b1, 16'd5, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int t = 0;
        sel3 = 1'b1;
        num_checks = 16'd4;
        halt_on_err = 1'b0;
        start3 = 1'b1;
        cyc();
        start3 = 1'b0;
        while (o_chk !== 16'd2 && t < 20) begin
            exp_valid = 1'b1;
            exp_data = DW'(t);
            obs3 = DW'(t - 3);
            cyc();
            t++;
        end
        total++;
        if (o_chk !== 16'd2) begin
            bad++;
            $display("FAIL reset_mid_reach: chk=%0d required 2 within 20 cycles", o_chk);
        end
        rst = 1'b1;
        exp_valid = 1'b0;
        cyc();
        rst = 1'b0;
        check_idle_zero("reset_mid");
        n_items = 4;
        for (int i = 0; i < 4; i++) load(i, i != 1, DW'(8'hE0 + i), 8'h00);
        drive_run(1'b1, 16'd3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        repeat (24) begin
            bit s3 = 1'($urandom);
            int n = $urandom_range(0, 6);
            logic h = 1'($urandom);
            int cnt = 0;
            n_items = 0;
            while ((cnt < n || n_items < 4) && n_items < 60) begin
                vld_a[n_items] = $urandom_range(0, 3) != 0;
                dat_a[n_items] = DW'($urandom);
                flp_a[n_items] = $urandom_range(0, 3) == 0 ? DW'($urandom_range(1, 255)) : '0;
                cnt += int'(vld_a[n_items]);
                n_items++;
            end
            if (cnt < n) n = cnt;
            drive_run(s3, CW'(n), h, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_continue_on_err();
        test_halt_on_err();
        test_bubbles();
        test_zero_checks();
        test_back_to_back_start();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
